// File: rtl/port_pkg.sv
// Shared types, constants and helpers for the MCU IO-port byte path.
// Used by port_fifo and port_buffer_ctrl.
package port_pkg;

  localparam logic [7:0] PORT_TYPE_SERIAL = 8'd0;
  localparam logic [7:0] AVAIL_MAX        = 8'd255;

  // Clamp a fill/free level to the 8-bit available field.
  function automatic logic [7:0] sat8(input logic [31:0] v);
    logic [7:0] r;
    r = AVAIL_MAX;
    if (v <= 32'(AVAIL_MAX))
      r = v[7:0];
    return r;
  endfunction

  // Status word: baud little-endian first, then frame byte.
  function automatic logic [31:0] pack_status(
    input logic [23:0] baud,
    input logic [7:0]  frame
  );
    return {baud[7:0], baud[15:8], baud[23:16], frame};
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Synchronous show-ahead byte FIFO with push/pop/flush, count and a drop pulse.
// Ports: clk, reset, flush, push, wdata, pop, rdata, count, full, empty, drop.
module port_fifo
  import port_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);
  assign count = cnt_q;
  assign rdata = empty ? 8'h00 : mem_q[rptr_q];

  // Pop is judged first so a full FIFO can accept a same-cycle push;
  // on an empty FIFO the pop is simply ignored.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && !do_push;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push)
        wptr_d = wptr_q + AW'(1);
      if (do_pop)
        rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: empty gates the head to zero.
  always_ff @(posedge clk) begin
    if (do_push && !reset)
      mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/port_buffer_ctrl.sv
// Port byte-path buffer between the system control block and the core UART.
// Ports: port_* (MCU side), rx_*/tx_* (core side), cfg_* status, overrun flags.
module port_buffer_ctrl
  import port_pkg::*;
#(
  parameter int OUT_AW = 4,
  parameter int IN_AW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  output logic [7:0]  port_out_available,
  input  logic        port_out_strobe,
  output logic [7:0]  port_out_data,
  output logic [7:0]  port_in_available,
  input  logic        port_in_strobe,
  input  logic [7:0]  port_in_data,
  output logic [31:0] port_status,
  input  logic [23:0] cfg_baud,
  input  logic [7:0]  cfg_frame,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        out_overrun,
  output logic        in_overrun
);

  localparam logic [IN_AW:0] IN_DEPTH = {1'b1, {IN_AW{1'b0}}};

  logic [OUT_AW:0] out_cnt;
  logic            out_full, out_empty, out_drop;
  logic [IN_AW:0]  in_cnt;
  logic            in_full, in_empty, in_drop;
  logic [IN_AW:0]  in_free;
  logic            out_ovr_q, out_ovr_d;
  logic            in_ovr_q, in_ovr_d;

  port_fifo #(.AW(OUT_AW)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (rx_strobe),
    .wdata (rx_data),
    .pop   (port_out_strobe),
    .rdata (port_out_data),
    .count (out_cnt),
    .full  (out_full),
    .empty (out_empty),
    .drop  (out_drop)
  );

  port_fifo #(.AW(IN_AW)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (port_in_strobe),
    .wdata (port_in_data),
    .pop   (tx_ready),
    .rdata (tx_data),
    .count (in_cnt),
    .full  (in_full),
    .empty (in_empty),
    .drop  (in_drop)
  );

  assign tx_valid = !in_empty;
  assign in_free  = IN_DEPTH - in_cnt;

  assign port_out_available = sat8(32'(out_cnt));
  assign port_in_available  = sat8(32'(in_free));
  assign port_status        = pack_status(cfg_baud, cfg_frame);

  always_comb begin
    out_ovr_d = out_ovr_q;
    in_ovr_d  = in_ovr_q;
    if (flush) begin
      out_ovr_d = 1'b0;
      in_ovr_d  = 1'b0;
    end else begin
      if (out_drop)
        out_ovr_d = 1'b1;
      if (in_drop)
        in_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ovr_q <= 1'b0;
      in_ovr_q  <= 1'b0;
    end else begin
      out_ovr_q <= out_ovr_d;
      in_ovr_q  <= in_ovr_d;
    end
  end

  assign out_overrun = out_ovr_q;
  assign in_overrun  = in_ovr_q;

  logic unused;
  assign unused = ^{out_full, out_empty, in_full};

endmodule

// File: tb/tb_port_buffer_ctrl.sv
// Self-checking bench for port_buffer_ctrl: queue model plus directed vectors.
// Model compared on every falling edge; literal checks pin key points.
module tb_port_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [7:0]  port_out_available;
  logic        port_out_strobe;
  logic [7:0]  port_out_data;
  logic [7:0]  port_in_available;
  logic        port_in_strobe;
  logic [7:0]  port_in_data;
  logic [31:0] port_status;
  logic [23:0] cfg_baud;
  logic [7:0]  cfg_frame;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        out_overrun, in_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  port_buffer_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .port_out_available (port_out_available),
    .port_out_strobe    (port_out_strobe),
    .port_out_data      (port_out_data),
    .port_in_available  (port_in_available),
    .port_in_strobe     (port_in_strobe),
    .port_in_data       (port_in_data),
    .port_status        (port_status),
    .cfg_baud           (cfg_baud),
    .cfg_frame          (cfg_frame),
    .rx_strobe          (rx_strobe),
    .rx_data            (rx_data),
    .tx_valid           (tx_valid),
    .tx_data            (tx_data),
    .tx_ready           (tx_ready),
    .out_overrun        (out_overrun),
    .in_overrun         (in_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: two byte queues of capacity 16 and two flags.
  byte unsigned oq[$];
  byte unsigned iq[$];
  bit m_oovr, m_iovr;
  bit mvalid = 0;

  always @(posedge clk) begin
    if (reset) begin
      oq.delete(); iq.delete();
      m_oovr = 0; m_iovr = 0;
      mvalid = 1;
    end else if (flush) begin
      oq.delete(); iq.delete();
      m_oovr = 0; m_iovr = 0;
    end else begin
      int osz, isz;
      osz = oq.size();
      isz = iq.size();
      if (port_out_strobe && osz > 0) void'(oq.pop_front());
      if (rx_strobe) begin
        if (oq.size() < 16) oq.push_back(rx_data);
        else m_oovr = 1;
      end
      if (tx_ready && isz > 0) void'(iq.pop_front());
      if (port_in_strobe) begin
        if (iq.size() < 16) iq.push_back(port_in_data);
        else m_iovr = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_out_avail", 32'(port_out_available), 32'(oq.size()));
      chk("m_out_data", 32'(port_out_data),
          oq.size() > 0 ? 32'(oq[0]) : 32'd0);
      chk("m_in_avail", 32'(port_in_available), 32'(16 - iq.size()));
      chk("m_tx_valid", 32'(tx_valid), 32'(iq.size() > 0));
      chk("m_tx_data", 32'(tx_data),
          iq.size() > 0 ? 32'(iq[0]) : 32'd0);
      chk("m_out_ovr", 32'(out_overrun), 32'(m_oovr));
      chk("m_in_ovr", 32'(in_overrun), 32'(m_iovr));
      chk("m_status", port_status,
          {cfg_baud[7:0], cfg_baud[15:8], cfg_baud[23:16], cfg_frame});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; flush = 0;
    port_out_strobe = 0; port_in_strobe = 0; port_in_data = 0;
    rx_strobe = 0; rx_data = 0; tx_ready = 0;
    cfg_baud = 24'd9600; cfg_frame = 8'h1B;
    cyc(); cyc();
    reset = 0;
    cyc();
    chk("rst_out_avail", 32'(port_out_available), 32'd0);
    chk("rst_in_avail", 32'(port_in_available), 32'd16);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_out_data", 32'(port_out_data), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    // Three pushes, availability follows one cycle later.
    rx_strobe = 1; rx_data = 8'h41; cyc();
    chk("push1_avail", 32'(port_out_available), 32'd1);
    rx_data = 8'h42; cyc();
    chk("push2_avail", 32'(port_out_available), 32'd2);
    rx_data = 8'h43; cyc();
    chk("push3_avail", 32'(port_out_available), 32'd3);
    rx_strobe = 0;
    chk("head_41", 32'(port_out_data), 32'h41);
    port_out_strobe = 1; cyc();
    chk("head_42", 32'(port_out_data), 32'h42);
    cyc();
    chk("head_43", 32'(port_out_data), 32'h43);
    cyc();
    port_out_strobe = 0;
    chk("drained_avail", 32'(port_out_available), 32'd0);
    chk("drained_data", 32'(port_out_data), 32'd0);

    // Pop from empty is ignored.
    port_out_strobe = 1; cyc(); port_out_strobe = 0;
    chk("pop_empty", 32'(port_out_available), 32'd0);

    // Overfill: 17th byte dropped.
    rx_strobe = 1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'(8'h80 + i); cyc();
    end
    rx_strobe = 0;
    chk("ovf_avail", 32'(port_out_available), 32'd16);
    chk("ovf_flag", 32'(out_overrun), 32'd1);
    chk("ovf_head", 32'(port_out_data), 32'h80);

    // Flush with coincident push: push discarded.
    flush = 1; rx_strobe = 1; rx_data = 8'hEE; cyc();
    flush = 0; rx_strobe = 0;
    chk("flush_avail", 32'(port_out_available), 32'd0);
    chk("flush_flag", 32'(out_overrun), 32'd0);

    // MCU->core byte.
    port_in_strobe = 1; port_in_data = 8'h55; cyc();
    port_in_strobe = 0;
    chk("tx_valid1", 32'(tx_valid), 32'd1);
    chk("tx_data55", 32'(tx_data), 32'h55);
    chk("in_avail15", 32'(port_in_available), 32'd15);
    tx_ready = 1; cyc(); tx_ready = 0;
    chk("tx_valid0", 32'(tx_valid), 32'd0);
    chk("in_avail16", 32'(port_in_available), 32'd16);

    // Push+pop on empty in-FIFO: push only.
    port_in_strobe = 1; port_in_data = 8'h66; tx_ready = 1; cyc();
    port_in_strobe = 0; tx_ready = 0;
    chk("pp_empty_valid", 32'(tx_valid), 32'd1);
    chk("pp_empty_data", 32'(tx_data), 32'h66);
    tx_ready = 1; cyc(); tx_ready = 0;

    // Offset out pointers, then fill, then push+pop while full across wrap.
    for (int i = 0; i < 5; i++) begin
      rx_strobe = 1; rx_data = 8'(i); cyc();
      rx_strobe = 0; port_out_strobe = 1; cyc(); port_out_strobe = 0;
    end
    rx_strobe = 1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h10 + i); cyc();
    end
    port_out_strobe = 1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(8'hA0 + i); cyc();
    end
    rx_strobe = 0;
    chk("full_pp_avail", 32'(port_out_available), 32'd16);
    chk("full_pp_ovr", 32'(out_overrun), 32'd0);
    chk("full_pp_head", 32'(port_out_data), 32'h14);
    for (int i = 0; i < 16; i++) cyc();
    port_out_strobe = 0;
    chk("wrap_drained", 32'(port_out_available), 32'd0);

    // Overfill the in-FIFO.
    port_in_strobe = 1;
    for (int i = 0; i < 18; i++) begin
      port_in_data = 8'(8'hC0 + i); cyc();
    end
    port_in_strobe = 0;
    chk("in_full_avail", 32'(port_in_available), 32'd0);
    chk("in_ovr", 32'(in_overrun), 32'd1);
    chk("in_head", 32'(tx_data), 32'hC0);

    // Status packing.
    cfg_baud = 24'd115200; cfg_frame = 8'h03; #1;
    chk("status", port_status, 32'h00C20103);

    // Reset mid-transfer.
    rx_strobe = 1; rx_data = 8'h77; reset = 1; cyc();
    rx_strobe = 0; cyc(); reset = 0; cyc();
    chk("rst2_out", 32'(port_out_available), 32'd0);
    chk("rst2_in", 32'(port_in_available), 32'd16);
    chk("rst2_ovr", 32'(in_overrun), 32'd0);
    chk("rst2_status", port_status, 32'h00C20103);

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
